// File: rtl/alu_pkg.sv
// Shared ALU definitions: nibble width, sequencer state encoding and
// flag bit positions used when packing flags into an ALU flag word.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

endpackage

// File: rtl/serial_add32_cla4.sv
// 4-bit carry-lookahead slice: the only arithmetic element of the serial adder.
// Carries are built from generate/propagate terms, so no '+' is inferred.
module cla4
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c4
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c[NIBBLE_W-1:0];
  assign c4 = c[NIBBLE_W];

endmodule

// File: rtl/serial_add32.sv
// Multi-cycle add/sub: feeds one CLA4 slice a nibble per clock, LSB first,
// with a registered carry, and assembles sum plus C/V/Z flags.
module serial_add32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STEPS = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [IDX_W+1:0]    bit_base;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_c4;

  // Nibble idx starts at bit idx*4; NIBBLE_W is 4, so a shift does it.
  assign bit_base = {idx_q, 2'b00};
  assign nib_a    = a_q[bit_base +: NIBBLE_W];
  assign nib_b    = b_q[bit_base +: NIBBLE_W];

  cla4 u_cla4 (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry_q),
    .s   (nib_s),
    .c4  (nib_c4)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_d         = a;
          b_d         = sub ? ~b : b;
          carry_d     = sub;
          idx_d       = '0;
          sum_d       = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        sum_d[bit_base +: NIBBLE_W] = nib_s;
        carry_d = nib_c4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          carry_out_d = nib_c4;
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIBBLE_W-1] != a_q[WIDTH-1]);
          zero_d      = (sum_d == '0);
          done_d      = 1'b1;
          idx_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add32.sv
// Scoreboard bench for serial_add32: stimulus pushes expected results from a
// plain-arithmetic model; a negedge monitor pops and compares on each done.
module tb_serial_add32;

  localparam int WIDTH = 32;
  localparam int STEPS = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ready, done, carry_out, overflow, zero;
  logic [WIDTH-1:0] sum;

  serial_add32 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;
    int               due;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: whole-word arithmetic, no nibbles.
  function automatic exp_t model(input logic s_op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    logic [WIDTH:0] wide;
    if (s_op) begin
      e.s = x - y;
      e.c = (x >= y);
      e.v = (x[WIDTH-1] != y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
    end else begin
      wide = {1'b0, x} + {1'b0, y};
      e.s = wide[WIDTH-1:0];
      e.c = wide[WIDTH];
      e.v = (x[WIDTH-1] == y[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
    end
    e.z = (e.s == '0);
    e.due = 0;
    e.tag = "";
    return e;
  endfunction

  // Called at a negedge; drives one start cycle and returns at the next negedge.
  task automatic issue(input logic s_op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic accept);
    exp_t e;
    start = 1'b1;
    sub   = s_op;
    a     = x;
    b     = y;
    check("ready_at_start", {31'b0, ready}, {31'b0, accept});
    if (accept) begin
      e = model(s_op, x, y);
      e.due = cyc + 1 + STEPS;
      e.tag = $sformatf("%s %h,%h", s_op ? "sub" : "add", x, y);
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sub   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'b0, ready}, 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, {31'b0, ready}, 32'd1);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_sum"}, sum, 32'd0);
    check({tag, "_flags"}, {29'b0, zero, overflow, carry_out}, 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc, e.due);
        check("sum", sum, e.s);
        check("carry_out", {31'b0, carry_out}, {31'b0, e.c});
        check("overflow", {31'b0, overflow}, {31'b0, e.v});
        check("zero", {31'b0, zero}, {31'b0, e.z});
        $display("op %s -> sum=0x%h c=%0b v=%0b z=%0b (cycle %0d)",
                 e.tag, sum, carry_out, overflow, zero, cyc);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    // Directed corner cases.
    issue(1'b0, 32'h0000000F, 32'h00000001, 1'b1); wait_idle();
    issue(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1); wait_idle();
    issue(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b1); wait_idle();
    issue(1'b1, 32'h00000005, 32'h00000007, 1'b1); wait_idle();
    issue(1'b1, 32'h80000000, 32'h00000001, 1'b1); wait_idle();
    @(negedge clk);

    // Start during RUN is ignored; start during the done cycle is accepted.
    issue(1'b0, 32'h1, 32'h2, 1'b1);
    repeat (2) @(negedge clk);
    issue(1'b0, 32'h100, 32'h100, 1'b0);
    repeat (5) @(negedge clk);
    check("done_cycle", {31'b0, done}, 32'd1);
    issue(1'b0, 32'h100, 32'h100, 1'b1);
    check("results_cleared_after_restart", sum, 32'd0);
    wait_idle();
    @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    issue(1'b0, 32'h12345678, 32'h11111111, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check_cleared("abort");
    repeat (12) @(negedge clk);
    issue(1'b0, 32'h2, 32'h3, 1'b1); wait_idle();

    // Random operations, with some biased operands and some back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: rb = ra;
        default: ;
      endcase
      issue(1'($urandom), ra, rb, 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
